// File: rtl/fetch_byte_seq_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, bus widths, FSM states.
package fetch_byte_seq_pkg;

  localparam int unsigned ICODE_BUS = 4;
  localparam int unsigned ADDR_BUS  = 64;

  localparam logic [ICODE_BUS-1:0] IHALT   = 4'h0, INOP    = 4'h1, IRRMOVQ = 4'h2,
                                   IIRMOVQ = 4'h3, IRMMOVQ = 4'h4, IMRMOVQ = 4'h5,
                                   IOPQ    = 4'h6, IJXX    = 4'h7, ICALL   = 4'h8,
                                   IRET    = 4'h9, IPUSHQ  = 4'hA, IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    StatAok = 3'd1,
    StatHlt = 3'd2,
    StatAdr = 3'd3,
    StatIns = 3'd4
  } stat_e;

  typedef enum logic [2:0] {StOp, StReg, StConst, StOut, StStop} state_e;

endpackage

// File: rtl/fetch_byte_seq_instr_len_decode.sv
// Combinational decode of the opcode byte into field requirements, legality and length.
module fetch_byte_seq_instr_len_decode
  import fetch_byte_seq_pkg::*;
(
  input  logic [ICODE_BUS-1:0] icode_i,
  input  logic [3:0]           ifun_i,
  output logic                 need_regids_o,
  output logic                 need_valc_o,
  output logic                 instr_ok_o,
  output logic [3:0]           len_o
);

  logic regids, valc, ok;

  always_comb begin
    regids = 1'b0;
    valc   = 1'b0;
    ok     = 1'b0;
    unique case (icode_i)
      IHALT, INOP, IRET: ok = (ifun_i == 4'h0);
      IRRMOVQ: begin
        regids = 1'b1;
        ok     = (ifun_i <= 4'h6);
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        regids = 1'b1;
        valc   = 1'b1;
        ok     = (ifun_i == 4'h0);
      end
      IOPQ: begin
        regids = 1'b1;
        ok     = (ifun_i <= 4'h3);
      end
      IJXX: begin
        valc = 1'b1;
        ok   = (ifun_i <= 4'h6);
      end
      ICALL: begin
        valc = 1'b1;
        ok   = (ifun_i == 4'h0);
      end
      IPUSHQ, IPOPQ: begin
        regids = 1'b1;
        ok     = (ifun_i == 4'h0);
      end
      default: ok = 1'b0;
    endcase
    // Illegal opcodes are reported as a single-byte instruction.
    if (!ok) begin
      regids = 1'b0;
      valc   = 1'b0;
    end
    need_regids_o = regids;
    need_valc_o   = valc;
    instr_ok_o    = ok;
    len_o         = 4'd1 + {3'd0, regids} + {valc, 3'd0};
  end

endmodule

// File: rtl/fetch_byte_seq.sv
// Byte-serial Y86-64 instruction fetcher with valid/ready output handshake.
// Optional ack timeout enabled by defining IMEM_TIMEOUT_EN.
module fetch_byte_seq
  import fetch_byte_seq_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] RESET_PC       = '0,
  parameter int unsigned         TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDR_BUS-1:0]  next_pc_i,
  output logic                 imem_req_o,
  output logic [ADDR_BUS-1:0]  imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [7:0]           imem_data_i,
  input  logic                 imem_err_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [ADDR_BUS-1:0]  pc_o,
  output logic [ICODE_BUS-1:0] icode_o,
  output logic [3:0]           ifun_o,
  output logic [3:0]           rA_o,
  output logic [3:0]           rB_o,
  output logic [63:0]          valC_o,
  output logic [ADDR_BUS-1:0]  valP_o,
  output logic [2:0]           stat_o
);

  state_e                 state_q;
  logic [ADDR_BUS-1:0]    pc_q, addr_q, valp_q;
  logic                   req_q, valid_q, need_valc_q;
  logic [ICODE_BUS-1:0]   icode_q;
  logic [3:0]             ifun_q, ra_q, rb_q;
  logic [63:0]            valc_q;
  stat_e                  stat_q;
  logic [2:0]             cnt_q;

  logic                   dec_regids, dec_valc, dec_ok;
  logic [3:0]             dec_len, op_len;
  stat_e                  op_stat;
  logic                   byte_ack, byte_ok, abort, go_out, tmo_hit;

  fetch_byte_seq_instr_len_decode u_len_decode (
    .icode_i       (imem_data_i[7:4]),
    .ifun_i        (imem_data_i[3:0]),
    .need_regids_o (dec_regids),
    .need_valc_o   (dec_valc),
    .instr_ok_o    (dec_ok),
    .len_o         (dec_len)
  );

  // Acks are only honoured against our own outstanding request.
  assign byte_ack = req_q & imem_ack_i;
  assign byte_ok  = byte_ack & ~imem_err_i;
  assign abort    = (byte_ack & imem_err_i) | tmo_hit;

`ifdef IMEM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  // A same-cycle ack takes priority over the timeout.
  assign tmo_hit = req_q & ~imem_ack_i & (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !req_q || imem_ack_i || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    op_len  = byte_ok ? dec_len : 4'd1;
    op_stat = StatAok;
    if (abort) begin
      op_stat = StatAdr;
    end else if (!dec_ok) begin
      op_stat = StatIns;
    end else if (imem_data_i[7:4] == IHALT) begin
      op_stat = StatHlt;
    end
    go_out = 1'b0;
    unique case (state_q)
      StOp:    go_out = abort | (byte_ok & (!dec_ok || imem_data_i[7:4] == IHALT ||
                                            (!dec_regids && !dec_valc)));
      StReg:   go_out = abort | (byte_ok & ~need_valc_q);
      StConst: go_out = abort | (byte_ok & (cnt_q == 3'd7));
      default: go_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StOp;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      need_valc_q <= 1'b0;
      icode_q     <= IHALT;
      ifun_q      <= 4'h0;
      ra_q        <= RNONE;
      rb_q        <= RNONE;
      valc_q      <= '0;
      valp_q      <= RESET_PC;
      stat_q      <= StatAok;
      cnt_q       <= '0;
    end else begin
      if (byte_ack) begin
        addr_q <= addr_q + 1'b1;
      end
      if (go_out) begin
        req_q   <= 1'b0;
        valid_q <= 1'b1;
        state_q <= StOut;
      end
      unique case (state_q)
        StOp: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end
          if (byte_ack || tmo_hit) begin
            icode_q     <= IHALT;
            ifun_q      <= 4'h0;
            ra_q        <= RNONE;
            rb_q        <= RNONE;
            valc_q      <= '0;
            cnt_q       <= '0;
            need_valc_q <= dec_valc;
            valp_q      <= pc_q + {{(ADDR_BUS-4){1'b0}}, op_len};
            stat_q      <= op_stat;
            if (byte_ok) begin
              icode_q <= imem_data_i[7:4];
              ifun_q  <= imem_data_i[3:0];
              if (!go_out) begin
                state_q <= dec_regids ? StReg : StConst;
              end
            end
          end
        end
        StReg: begin
          if (byte_ok) begin
            ra_q <= imem_data_i[7:4];
            rb_q <= imem_data_i[3:0];
            if (!go_out) begin
              state_q <= StConst;
            end
          end else if (abort) begin
            stat_q <= StatAdr;
          end
        end
        StConst: begin
          if (byte_ok) begin
            valc_q[{cnt_q, 3'b000} +: 8] <= imem_data_i;
            cnt_q                        <= cnt_q + 1'b1;
          end else if (abort) begin
            stat_q <= StatAdr;
          end
        end
        StOut: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            if (stat_q == StatAok) begin
              pc_q    <= next_pc_i;
              addr_q  <= next_pc_i;
              req_q   <= 1'b1;
              state_q <= StOp;
            end else begin
              state_q <= StStop;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign icode_o       = icode_q;
  assign ifun_o        = ifun_q;
  assign rA_o          = ra_q;
  assign rB_o          = rb_q;
  assign valC_o        = valc_q;
  assign valP_o        = valp_q;
  assign stat_o        = stat_q;

endmodule
